branch_predict_unit: RTL and testbench

Parametrised successor to the single-cycle branch resolver. It adds a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters, queried in IF. Branches, JAL and JALR are resolved in EX, producing a redirect on misprediction and training the table. It also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predict_unit_pkg.sv | 41 ++++
 rtl/branch_predict_unit_if.sv | 52 +++++
 rtl/branch_predict_unit_sat_counter32.sv | 27 ++
 rtl/branch_predict_unit.sv | 120 ++++++++++++
 tb/tb_branch_predict_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and helpers for the branch predict unit.
//               Holds the default configuration (PC width, BTB depth and
//               counter width), the BTB entry layout, the counter reset and
//               allocation values, and the saturating counter step.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int BP_PC_W    = 9;
    localparam int BP_ENTRIES = 16;
    localparam int BP_CNT_W   = 2;

    localparam int BP_IDX_W = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 2;

    // The counter resets to weakly not-taken. A fresh allocation starts one
    // step higher, at weakly taken.
    localparam logic [BP_CNT_W-1:0] CNT_INIT       = BP_CNT_W'((1 << (BP_CNT_W - 1)) - 1);
    localparam logic [BP_CNT_W-1:0] CNT_WEAK_TAKEN = BP_CNT_W'(1 << (BP_CNT_W - 1));

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        logic [BP_CNT_W-1:0] cnt;
    } bp_entry_t;

    // One saturating step: up when taken, down when not taken.
    function automatic logic [BP_CNT_W-1:0] cnt_next(input logic [BP_CNT_W-1:0] cnt,
                                                     input logic                taken);
        if (taken) begin
            return (cnt == '1) ? cnt : cnt + BP_CNT_W'(1);
        end
        return (cnt == '0) ? cnt : cnt - BP_CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit_if
// Description : Bundle between the core pipeline and the branch predict unit.
//               It carries the IF lookup, the EX resolution inputs, the
//               redirect/link outputs and the statistics counters.
//               master : pipeline side (drives the PCs and EX info, receives
//                        the predictions and redirects)
//               slave  : predictor side
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predict_unit_if
    import bp_pkg::*;
#(
    parameter int PC_W = BP_PC_W
);
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic [31:0]     pred_target;

    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic            ex_branch;
    logic            ex_jal;
    logic            ex_jalr;
    logic [31:0]     ex_imm;
    logic [31:0]     ex_alu_result;
    logic            ex_pred_taken;
    logic [31:0]     ex_pred_target;
    logic            flag_halt;

    logic            redirect;
    logic [31:0]     redirect_pc;
    logic [31:0]     pc_four;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_branch, ex_jal, ex_jalr, ex_imm,
               ex_alu_result, ex_pred_taken, ex_pred_target, flag_halt,
        input  pred_taken, pred_target, redirect, redirect_pc, pc_four,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_branch, ex_jal, ex_jalr, ex_imm,
               ex_alu_result, ex_pred_taken, ex_pred_target, flag_halt,
        output pred_taken, pred_target, redirect, redirect_pc, pc_four,
               stat_branches, stat_mispredicts
    );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit_sat_counter32.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter32
// Description : 32-bit event counter that sticks at all-ones. It increments
//               on inc unless freeze is set, and resets asynchronously.
//               clk, reset : clock / async active-high reset
//               inc        : count one event this cycle
//               freeze     : hold the current value
//               count      : current value
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter32 (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        inc,
    input  wire logic        freeze,
    output logic      [31:0] count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !freeze && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Direct-mapped BTB with saturating direction counters. It is
//               looked up combinationally in IF and trained from the EX
//               resolution of branches, JAL and JALR. On a misprediction it
//               raises a zero-latency redirect, and it counts resolved
//               control transfers and redirects.
//               clk, reset : clock / async active-high reset
//               bp         : pipeline bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_W    = BP_PC_W,
    parameter int ENTRIES = BP_ENTRIES,
    parameter int CNT_W   = BP_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    branch_predict_unit_if.slave  bp
);
    localparam int c_IDX_W = $clog2(ENTRIES);

    bp_entry_t r_table [ENTRIES];

    // ---------------- IF lookup ----------------
    logic [c_IDX_W-1:0]        w_if_idx;
    logic [PC_W-c_IDX_W-3:0]   w_if_tag;
    bp_entry_t                 w_if_ent;
    logic                      w_if_hit;

    assign w_if_idx = bp.if_pc[c_IDX_W+1:2];
    assign w_if_tag = bp.if_pc[PC_W-1:c_IDX_W+2];
    assign w_if_ent = r_table[w_if_idx];
    assign w_if_hit = w_if_ent.valid && (w_if_ent.tag == w_if_tag);

    assign bp.pred_taken  = w_if_hit && w_if_ent.cnt[CNT_W-1] && !bp.flag_halt;
    assign bp.pred_target = bp.pred_taken ? 32'(w_if_ent.target) : 32'd0;

    // ---------------- EX resolution ----------------
    logic [c_IDX_W-1:0]        w_ex_idx;
    logic [PC_W-c_IDX_W-3:0]   w_ex_tag;
    bp_entry_t                 w_ex_ent;
    logic                      w_ex_hit;
    logic                      w_is_cti;
    logic                      w_act_taken;
    logic [31:0]               w_target;
    logic [31:0]               w_pc_four;
    logic                      w_cti_miss;
    logic                      w_stale_alias;

    assign w_ex_idx = bp.ex_pc[c_IDX_W+1:2];
    assign w_ex_tag = bp.ex_pc[PC_W-1:c_IDX_W+2];
    assign w_ex_ent = r_table[w_ex_idx];
    assign w_ex_hit = w_ex_ent.valid && (w_ex_ent.tag == w_ex_tag);

    assign w_is_cti    = bp.ex_valid && (bp.ex_branch || bp.ex_jal || bp.ex_jalr);
    assign w_act_taken = bp.ex_jal || bp.ex_jalr || (bp.ex_branch && bp.ex_alu_result[0]);

    // JALR wins over JAL/branch when several flags are set, so it alone
    // selects the register target; JAL and branch share the PC-relative one.
    assign w_target  = bp.ex_jalr ? {bp.ex_alu_result[31:1], 1'b0}
                                  : 32'(bp.ex_pc) + bp.ex_imm;
    assign w_pc_four = 32'(bp.ex_pc) + 32'd4;

    assign w_cti_miss = w_is_cti &&
                        ((w_act_taken != bp.ex_pred_taken) ||
                         (w_act_taken && (bp.ex_pred_target != w_target)));
    // A non-CTI that was fetched as taken means the BTB entry aliased onto
    // a different instruction; fall through and drop the entry.
    assign w_stale_alias = bp.ex_valid && !w_is_cti && bp.ex_pred_taken;

    assign bp.redirect    = w_cti_miss || w_stale_alias;
    assign bp.redirect_pc = w_act_taken ? w_target : w_pc_four;
    assign bp.pc_four     = w_pc_four;

    // ---------------- Training ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_INIT};
            end
        end else if (!bp.flag_halt) begin
            if (w_is_cti) begin
                if (w_ex_hit) begin
                    r_table[w_ex_idx].cnt <= cnt_next(w_ex_ent.cnt, w_act_taken);
                    if (w_act_taken) begin
                        r_table[w_ex_idx].target <= w_target[PC_W-1:0];
                    end
                end else if (w_act_taken) begin
                    r_table[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag,
                                           target: w_target[PC_W-1:0],
                                           cnt: CNT_WEAK_TAKEN};
                end
            end else if (w_stale_alias && w_ex_hit) begin
                r_table[w_ex_idx].valid <= 1'b0;
            end
        end
    end

    // ---------------- Statistics ----------------
    bp_sat_counter32 u_stat_branches (
        .clk    (clk),
        .reset  (reset),
        .inc    (w_is_cti),
        .freeze (bp.flag_halt),
        .count  (bp.stat_branches)
    );

    bp_sat_counter32 u_stat_mispredicts (
        .clk    (clk),
        .reset  (reset),
        .inc    (bp.redirect),
        .freeze (bp.flag_halt),
        .count  (bp.stat_mispredicts)
    );
endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Self-checking bench for branch_predict_unit. A table of
//               one-cycle vectors walks the BTB through allocation, counter
//               saturation, JAL/JALR, aliasing and invalidation. Short
//               directed sequences then exercise halt and an asynchronous
//               mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    logic clk;
    logic reset;

    branch_predict_unit_if #(.PC_W(9)) bus ();

    branch_predict_unit #(.PC_W(9), .ENTRIES(16), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  if_pc;
        logic        valid;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [8:0]  ex_pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_pred;
        logic [31:0] e_ptgt;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    function automatic vec_t mk(input logic [8:0] if_pc, input logic valid,
                                input logic br, input logic jal, input logic jalr,
                                input logic [8:0] ex_pc, input logic [31:0] imm,
                                input logic [31:0] alu, input logic pt,
                                input logic [31:0] ptgt, input logic e_pred,
                                input logic [31:0] e_ptgt, input logic e_redir,
                                input logic [31:0] e_rpc, input logic [31:0] e_pc4);
        vec_t v;
        v.if_pc = if_pc; v.valid = valid; v.br = br; v.jal = jal; v.jalr = jalr;
        v.ex_pc = ex_pc; v.imm = imm; v.alu = alu; v.pt = pt; v.ptgt = ptgt;
        v.e_pred = e_pred; v.e_ptgt = e_ptgt; v.e_redir = e_redir;
        v.e_rpc = e_rpc; v.e_pc4 = e_pc4;
        return v;
    endfunction

    // Bubble in EX (ex_pc parked at 0x40), lookup only.
    function automatic vec_t idle(input logic [8:0] if_pc, input logic e_pred,
                                  input logic [31:0] e_ptgt);
        return mk(if_pc, 0, 0, 0, 0, 9'h040, 32'd0, 32'd0, 0, 32'd0,
                  e_pred, e_ptgt, 0, 32'h44, 32'h44);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v, input logic halt);
        bus.if_pc          = v.if_pc;
        bus.ex_valid       = v.valid;
        bus.ex_branch      = v.br;
        bus.ex_jal         = v.jal;
        bus.ex_jalr        = v.jalr;
        bus.ex_pc          = v.ex_pc;
        bus.ex_imm         = v.imm;
        bus.ex_alu_result  = v.alu;
        bus.ex_pred_taken  = v.pt;
        bus.ex_pred_target = v.ptgt;
        bus.flag_halt      = halt;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, ".pred_taken"},  32'(bus.pred_taken), 32'(v.e_pred));
        check({tag, ".pred_target"}, bus.pred_target,     v.e_ptgt);
        check({tag, ".redirect"},    32'(bus.redirect),   32'(v.e_redir));
        check({tag, ".redirect_pc"}, bus.redirect_pc,     v.e_rpc);
        check({tag, ".pc_four"},     bus.pc_four,         v.e_pc4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t h;
        n_checks = 0;
        n_fail   = 0;

        // 0x40: idx 0, tag 1.  0x100: idx 0, tag 4.  0x80: idx 0, tag 2.
        vecs.push_back(idle(9'h040, 0, 32'h0));                                                          // v0
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 0, 32'h0,  0, 32'h0,  1, 32'h60, 32'h44)); // v1 cold taken -> alloc cnt2
        vecs.push_back(idle(9'h040, 1, 32'h60));                                                         // v2
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h0, 1, 32'h60, 1, 32'h60, 1, 32'h44, 32'h44)); // v3 nt -> cnt1
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h0, 0, 32'h0,  0, 32'h0,  0, 32'h44, 32'h44)); // v4 nt -> cnt0
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h0, 0, 32'h0,  0, 32'h0,  0, 32'h44, 32'h44)); // v5 nt, stays 0
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 0, 32'h0,  0, 32'h0,  1, 32'h60, 32'h44)); // v6 t -> cnt1
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 0, 32'h0,  0, 32'h0,  1, 32'h60, 32'h44)); // v7 t -> cnt2
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 1, 32'h60, 1, 32'h60, 0, 32'h60, 32'h44)); // v8 correct -> cnt3
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 1, 32'h60, 1, 32'h60, 0, 32'h60, 32'h44)); // v9 saturate at 3
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h0, 1, 32'h60, 1, 32'h60, 1, 32'h44, 32'h44)); // v10 nt -> cnt2
        vecs.push_back(idle(9'h040, 1, 32'h60));                                                         // v11
        vecs.push_back(mk(9'h100, 1,0,0,1, 9'h100, 32'h0, 32'h85, 0, 32'h0,  0, 32'h0,  1, 32'h84, 32'h104)); // v12 jalr, overwrite idx0
        vecs.push_back(idle(9'h100, 1, 32'h84));                                                         // v13
        vecs.push_back(idle(9'h000, 0, 32'h0));                                                          // v14 same idx, other tag
        vecs.push_back(mk(9'h100, 1,0,1,0, 9'h080, 32'hFFFF_FFF0, 32'h0, 1, 32'h70, 1, 32'h84, 0, 32'h70, 32'h84)); // v15 jal, pre-update lookup
        vecs.push_back(idle(9'h100, 0, 32'h0));                                                          // v16 evicted
        vecs.push_back(idle(9'h080, 1, 32'h70));                                                         // v17
        vecs.push_back(mk(9'h080, 1,0,0,0, 9'h080, 32'h0, 32'h0, 1, 32'h70, 1, 32'h70, 1, 32'h84, 32'h84)); // v18 stale alias
        vecs.push_back(idle(9'h080, 0, 32'h0));                                                          // v19 invalidated
        vecs.push_back(mk(9'h040, 0,0,0,0, 9'h040, 32'h0, 32'h0, 1, 32'h60, 0, 32'h0,  0, 32'h44, 32'h44)); // v20 bubble, 0x40 evicted by v12
        vecs.push_back(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 1, 32'h64, 0, 32'h0,  1, 32'h60, 32'h44)); // v21 wrong target, miss -> alloc cnt2
        vecs.push_back(mk(9'h1F0, 1,1,0,0, 9'h1F0, 32'hFFFF_FE00, 32'h1, 0, 32'h0, 0, 32'h0, 1, 32'hFFFF_FFF0, 32'h1F4)); // v22 32-bit wrap
        vecs.push_back(idle(9'h1F0, 1, 32'h1F0));                                                        // v23 truncated target
        vecs.push_back(mk(9'h020, 1,1,0,1, 9'h020, 32'h10, 32'h201, 0, 32'h0, 0, 32'h0, 1, 32'h200, 32'h24)); // v24 jalr over branch

        // Reset state
        reset = 1'b1;
        drive(idle(9'h040, 0, 32'h0), 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset.pred_taken",  32'(bus.pred_taken), 32'd0);
        check("reset.pred_target", bus.pred_target,     32'd0);
        check("reset.redirect",    32'(bus.redirect),   32'd0);
        check("reset.stat_br",     bus.stat_branches,   32'd0);
        check("reset.stat_mis",    bus.stat_mispredicts, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i], 1'b0);
            #1;
            check_vec($sformatf("v%0d", i), vecs[i]);
        end

        @(negedge clk);
        drive(idle(9'h040, 1, 32'h60), 1'b0);
        #1;
        check("table.stat_br",  bus.stat_branches,    32'd14);
        check("table.stat_mis", bus.stat_mispredicts, 32'd10);

        // Halt: mispredicted not-taken at 0x40 (cnt 2) still redirects,
        // prediction is suppressed, nothing trains.
        @(negedge clk);
        h = mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h0, 1, 32'h60, 0, 32'h0, 1, 32'h44, 32'h44);
        drive(h, 1'b1);
        #1;
        check_vec("halt1", h);
        @(negedge clk);
        h = mk(9'h010, 1,1,0,0, 9'h010, 32'h8, 32'h1, 0, 32'h0, 0, 32'h0, 1, 32'h18, 32'h14);
        drive(h, 1'b1);
        #1;
        check_vec("halt2", h);
        @(negedge clk);
        drive(idle(9'h010, 0, 32'h0), 1'b0);
        #1;
        check("halt.no_alloc",  32'(bus.pred_taken), 32'd0);
        check("halt.stat_br",   bus.stat_branches,    32'd14);
        check("halt.stat_mis",  bus.stat_mispredicts, 32'd10);
        @(negedge clk);
        drive(idle(9'h040, 1, 32'h60), 1'b0);
        #1;
        check("halt.cnt_kept", 32'(bus.pred_taken), 32'd1);
        // One more not-taken would drop cnt 2 -> 1 only if halt1 did not train.
        @(negedge clk);
        drive(mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h0, 0, 32'h0, 1, 32'h60, 0, 32'h44, 32'h44), 1'b0);
        @(negedge clk);
        drive(idle(9'h040, 0, 32'h0), 1'b0);
        #1;
        check("halt.cnt_step", 32'(bus.pred_taken), 32'd0);

        // Asynchronous reset mid-stream, away from any clock edge.
        @(negedge clk);
        h = mk(9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 0, 32'h0, 0, 32'h0, 1, 32'h60, 32'h44);
        drive(h, 1'b0);
        @(negedge clk);
        drive(idle(9'h040, 1, 32'h60), 1'b0);
        #1;
        check("pre_rst.pred", 32'(bus.pred_taken), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rst.pred_taken",  32'(bus.pred_taken),  32'd0);
        check("rst.pred_target", bus.pred_target,      32'd0);
        check("rst.stat_br",     bus.stat_branches,    32'd0);
        check("rst.stat_mis",    bus.stat_mispredicts, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst.pred", 32'(bus.pred_taken), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
